// File: rtl/npu_pipe_stage_if.sv
// Valid/ready bus of the elastic pipeline stage, plus flush and occupancy.
// The master side drives upstream data and downstream ready; the slave is the pipe.
interface npu_pipe_stage_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
);
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CW-1:0]    count;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/npu_pipe_stage.sv
// DEPTH-stage elastic pipeline register with per-stage valid, collapsing bubbles,
// flush and a registered occupancy count.
module npu_pipe_stage #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input logic             clk,
  input logic             reset,
  npu_pipe_stage_if.slave bus
);
  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_next;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic             in_ready_int;
  logic             acc;

  assign in_ready_int = ~bus.flush & (~v_q[0] | adv[0]);
  assign acc          = bus.in_valid & in_ready_int;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic             v_reg;
    logic [WIDTH-1:0] d_reg;
    logic             load;
    logic [WIDTH-1:0] src;
    logic             full_above;

    // The advance chain unrolls to: move if any later stage is empty, or the
    // output drains. This keeps every adv bit a flat function of the valids.
    if (gi == DEPTH - 1) begin : g_tail
      assign full_above = 1'b1;
    end else begin : g_mid
      assign full_above = &v_q[DEPTH-1:gi+1];
    end
    assign adv[gi] = v_reg & (~full_above | bus.out_ready);

    if (gi == 0) begin : g_head
      assign load = acc;
      assign src  = bus.in_data;
    end else begin : g_body
      assign load = adv[gi-1] & ~bus.flush;
      assign src  = d_q[gi-1];
    end

    assign v_next[gi] = ~bus.flush & (load | (v_reg & ~adv[gi]));

    always_ff @(posedge clk) begin
      if (!reset) begin
        v_reg <= 1'b0;
        d_reg <= '0;
      end else begin
        v_reg <= v_next[gi];
        if (load) begin
          d_reg <= src;
        end
      end
    end

    assign v_q[gi] = v_reg;
    assign d_q[gi] = d_reg;
  end

  always_comb begin
    count_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_next = count_next + CW'(v_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = v_q[DEPTH-1];
  assign bus.out_data  = d_q[DEPTH-1];
  assign bus.count     = count_reg;
endmodule

// File: tb/tb_npu_pipe_stage.sv
// Bench for npu_pipe_stage: directed tables and sequences plus random traffic,
// all checked against a queue-of-ages model of the pipe.
module tb_npu_pipe_stage;
  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  npu_pipe_stage_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) bus ();

  npu_pipe_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit         iv;
    logic [7:0] din;
    bit         ordy;
    bit         e_ir;
    bit         e_ov;
    logic [7:0] e_od;
    bit         c_od;
    int         e_cnt;
  } vec_t;

  // A word's stage is min(age, DEPTH-1-index): it climbs one stage per cycle
  // until it packs up behind the words ahead of it.
  typedef struct {
    logic [7:0] data;
    int         age;
  } ent_t;

  ent_t       q[$];
  logic [7:0] last_data_m;
  bit         model_ok = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         cur_rst, cur_fl, cur_iv, cur_ordy;
  logic [7:0] cur_din;
  vec_t       tbl [14];
  bit         r_rst, r_fl, r_iv, r_ordy;

  function automatic int posof(int k);
    int lim;
    lim = DEPTH - 1 - k;
    return (q[k].age < lim) ? q[k].age : lim;
  endfunction

  function automatic bit m_out_valid();
    if (q.size() == 0) return 1'b0;
    return posof(0) == DEPTH - 1;
  endfunction

  function automatic bit m_in_ready(bit fl, bit ordy);
    int rem, lim, np;
    if (fl) return 1'b0;
    rem = q.size() - ((m_out_valid() && ordy) ? 1 : 0);
    if (rem == 0) return 1'b1;
    lim = DEPTH - rem;
    np  = q[q.size()-1].age + 1;
    if (np > lim) np = lim;
    return np > 0;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(bit rst_n, bit fl, bit iv, logic [7:0] din, bit ordy);
    @(negedge clk);
    reset         = rst_n;
    bus.flush     = fl;
    bus.in_valid  = iv;
    bus.in_data   = din;
    bus.out_ready = ordy;
    cur_rst = rst_n; cur_fl = fl; cur_iv = iv; cur_din = din; cur_ordy = ordy;
    #1;
    if (model_ok) begin
      chk("model_in_ready",  32'(bus.in_ready),  32'(m_in_ready(fl, ordy)));
      chk("model_out_valid", 32'(bus.out_valid), 32'(m_out_valid()));
      chk("model_out_data",  32'(bus.out_data),  32'(last_data_m));
      chk("model_count",     32'(bus.count),     32'(q.size()));
    end
  endtask

  task automatic commit();
    bit pop, acc;
    @(posedge clk);
    if (!cur_rst) begin
      q.delete();
      last_data_m = '0;
      model_ok    = 1'b1;
    end else if (model_ok) begin
      pop = m_out_valid() && cur_ordy;
      acc = cur_iv && m_in_ready(cur_fl, cur_ordy);
      if (pop) begin
        $display("xfer out data=%02h t=%0t", q[0].data, $time);
        void'(q.pop_front());
      end
      if (cur_fl) begin
        q.delete();
      end else begin
        foreach (q[k]) q[k].age = q[k].age + 1;
        if (acc) begin
          $display("xfer in  data=%02h t=%0t", cur_din, $time);
          q.push_back('{data: cur_din, age: 0});
        end
        if (q.size() > 0 && posof(0) == DEPTH - 1) last_data_m = q[0].data;
      end
    end
  endtask

  initial begin
    reset = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;

    // Backpressure (first 7 rows) and bubble collapse (last 7 rows), from empty.
    tbl = '{
      '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0},
      '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1},
      '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 2},
      '{1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 2},
      '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 1'b1, 2},
      '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 1'b1, 1},
      '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 0},
      '{1'b1, 8'h05, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0},
      '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1},
      '{1'b1, 8'h06, 1'b0, 1'b1, 1'b1, 8'h05, 1'b1, 1},
      '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h05, 1'b1, 2},
      '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h05, 1'b1, 2},
      '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h06, 1'b1, 1},
      '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 0}
    };

    // Reset held two cycles with input offered.
    apply(1'b0, 1'b0, 1'b1, 8'hAA, 1'b1); commit();
    apply(1'b0, 1'b0, 1'b1, 8'hAA, 1'b1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_count",     32'(bus.count),     32'd0);
    commit();
    apply(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst2_out_data", 32'(bus.out_data),  32'd0);
    chk("rst2_count",    32'(bus.count),     32'd0);
    commit();

    // Streaming 0x01..0x10, then drain.
    for (int i = 0; i < 19; i++) begin
      apply(1'b1, 1'b0, i < 16, 8'(i + 1), 1'b1);
      chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
      chk("stream_out_valid", 32'(bus.out_valid), 32'(i >= 2 && i <= 17));
      if (i >= 2 && i <= 17) chk("stream_out_data", 32'(bus.out_data), 32'(i - 1));
      chk("stream_count", 32'(bus.count),
          32'((i == 0) ? 0 : (i == 1) ? 1 : (i <= 16) ? 2 : (i == 17) ? 1 : 0));
      commit();
    end

    foreach (tbl[r]) begin
      apply(1'b1, 1'b0, tbl[r].iv, tbl[r].din, tbl[r].ordy);
      chk($sformatf("tbl%0d_in_ready", r),  32'(bus.in_ready),  32'(tbl[r].e_ir));
      chk($sformatf("tbl%0d_out_valid", r), 32'(bus.out_valid), 32'(tbl[r].e_ov));
      if (tbl[r].c_od) chk($sformatf("tbl%0d_out_data", r), 32'(bus.out_data), 32'(tbl[r].e_od));
      chk($sformatf("tbl%0d_count", r), 32'(bus.count), 32'(tbl[r].e_cnt));
      commit();
    end

    // Flush of a full pipe while a new word is offered.
    apply(1'b1, 1'b0, 1'b1, 8'h07, 1'b0); commit();
    apply(1'b1, 1'b0, 1'b1, 8'h08, 1'b0); commit();
    apply(1'b1, 1'b1, 1'b1, 8'h09, 1'b0);
    chk("flush_in_ready",  32'(bus.in_ready),  32'd0);
    chk("flush_count_pre", 32'(bus.count),     32'd2);
    chk("flush_out_valid_pre", 32'(bus.out_valid), 32'd1);
    commit();
    apply(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("flush_count",     32'(bus.count),     32'd0);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    commit();
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("flush_no_09", 32'(bus.out_valid), 32'd0);
      commit();
    end

    // Reset pulse in the middle of a stream.
    apply(1'b1, 1'b0, 1'b1, 8'h20, 1'b1); commit();
    apply(1'b1, 1'b0, 1'b1, 8'h21, 1'b1); commit();
    apply(1'b0, 1'b0, 1'b1, 8'h22, 1'b1);
    chk("mrst_count_pre", 32'(bus.count), 32'd2);
    commit();
    apply(1'b1, 1'b0, 1'b1, 8'h30, 1'b1);
    chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_out_data",  32'(bus.out_data),  32'd0);
    chk("mrst_count",     32'(bus.count),     32'd0);
    chk("mrst_in_ready",  32'(bus.in_ready),  32'd1);
    commit();
    apply(1'b1, 1'b0, 1'b1, 8'h31, 1'b1);
    chk("mrst_lat_valid", 32'(bus.out_valid), 32'd0);
    commit();
    apply(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("mrst_first_valid", 32'(bus.out_valid), 32'd1);
    chk("mrst_first_data",  32'(bus.out_data),  32'h30);
    commit();
    apply(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("mrst_second_valid", 32'(bus.out_valid), 32'd1);
    chk("mrst_second_data",  32'(bus.out_data),  32'h31);
    commit();
    apply(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("mrst_empty", 32'(bus.out_valid), 32'd0);
    commit();

    // Random traffic with occasional flush and reset, checked by the model.
    for (int c = 0; c < 1500; c++) begin
      r_rst  = ($urandom_range(199) != 0);
      r_fl   = ($urandom_range(39) == 0);
      r_iv   = ($urandom_range(9) < 7);
      r_ordy = ($urandom_range(9) < 6);
      apply(r_rst, r_fl, r_iv, 8'($urandom), r_ordy);
      commit();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
